regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//   Shares the register file's single write port between two requesters: the writeback stage (WB, any register)
//   and the decode-stage link writer (LK, JAL return address, always $ra = r31).
//   Accepts one write per cycle and drives a registered write port to the register file.
//   Fixed WB priority; an anti-starvation counter forces a link grant after STARVE_LIMIT lost cycles.
// PARAMETERS
//   DATA_W        32  register data width
//   ADDR_W        5   register index width
//   STARVE_LIMIT  4   consecutive lost LK cycles before LK gets priority (1..15)
// PORTS
//   clk        in   1       single clock; all state updates on posedge
//   rst_n      in   1       asynchronous active-low reset
//   wb_valid   in   1       WB write request
//   wb_ready   out  1       WB request accepted this cycle (combinational grant)
//   wb_addr    in   ADDR_W  WB destination register
//   wb_data    in   DATA_W  WB write data
//   lk_valid   in   1       link write request (destination fixed to r31)
//   lk_ready   out  1       LK request accepted this cycle (combinational grant)
//   lk_data    in   DATA_W  return address
//   rf_we      out  1       register file write enable (registered)
//   rf_waddr   out  ADDR_W  register file write index (registered)
//   rf_wdata   out  DATA_W  register file write data (registered)
//   starved    out  1       high while the arbiter is in LK_PRI
// BEHAVIOUR
//   - Reset (async, rst_n=0): rf_we=0, rf_waddr=0, rf_wdata=0, state=WB_PRI, starve_cnt=0, starved=0.
//     Reset mid-transfer discards the registered write; requesters re-present after reset.
//   - Handshake: a request transfers when valid&&ready in the same cycle. Requesters hold valid/addr/data
//     stable until ready. ready never depends on the requester's own data.
//   - States: WB_PRI (default) and LK_PRI.
//     WB_PRI: wb_valid -> grant WB; else lk_valid -> grant LK.
//     LK_PRI: lk_valid -> grant LK; else wb_valid -> grant WB.
//   - Ordering override: in LK_PRI, if wb_valid && wb_addr==31, grant WB (older instruction's $ra write must land first).
//   - starve_cnt (4 bits, saturating): +1 each cycle lk_valid && !lk_ready; cleared on LK grant or when !lk_valid.
//     WB_PRI -> LK_PRI when starve_cnt reaches STARVE_LIMIT; LK_PRI -> WB_PRI on the cycle after an LK grant.
//   - Latency: a write granted in cycle N appears on rf_we/rf_waddr/rf_wdata in cycle N+1 (one posedge).
//     With no grant, rf_we=0 on the next cycle; rf_waddr/rf_wdata hold their last values.
//   - r0: a granted WB with wb_addr==0 is accepted (wb_ready=1) but produces rf_we=0.
//   - Exactly one grant per cycle; wb_ready&&lk_ready is never 1.
// CONFIGURATION
//   REGWR_BYPASS_EN defined: adds inputs rd_addr1, rd_addr2 (ADDR_W) and outputs byp_hit1, byp_hit2 (1),
//     byp_data1, byp_data2 (DATA_W). byp_hitK = rf_we && rf_waddr==rd_addrK && rd_addrK!=0; byp_dataK = rf_wdata.
//     Purely combinational from registered state; lets readers see a write in its commit cycle.
//   Undefined: those ports do not exist; behaviour otherwise identical.
// STRUCTURE
//   Shared package regfile_pkg: REG_ZERO=5'd0, REG_V0=5'd2, REG_V1=5'd3, REG_A0=5'd4, REG_SP=5'd29,
//     REG_FP=5'd30, REG_RA=5'd31; typedef enum {WB_PRI, LK_PRI} arb_state_t.
//   One sub-module: regwr_starve_ctr (saturating counter + limit compare, outputs limit_hit).
// TESTING
//   1. Reset: rst_n=0 asserted mid-cycle while requests pending -> rf_we=0 immediately, starved=0, state WB_PRI.
//   2. WB only: wb_addr=5, wb_data=0xDEADBEEF -> wb_ready=1 same cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
//   3. Contention: wb_valid and lk_valid (lk_data=0x00400010) both held -> WB wins 4 cycles; starved=1; 5th cycle
//      lk_ready=1; next cycle rf_waddr=31, rf_wdata=0x00400010; starved returns to 0.
//   4. Ordering: in LK_PRI with wb_addr=31, wb_data=0x11 -> WB granted first, LK next cycle; final r31=LK data.
//   5. r0 drop: wb_addr=0, wb_data=0xFFFFFFFF -> wb_ready=1, next cycle rf_we=0.
//   6. REGWR_BYPASS_EN: commit r8=0x1234 with rd_addr1=8, rd_addr2=0 -> byp_hit1=1, byp_data1=0x1234, byp_hit2=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Register-file write arbitration shared types: well-known register indices and arbiter states.
// Pure declarations; no timing or flow-control of its own.
package regfile_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_V0   = 5'd2;
  localparam logic [4:0] REG_V1   = 5'd3;
  localparam logic [4:0] REG_A0   = 5'd4;
  localparam logic [4:0] REG_SP   = 5'd29;
  localparam logic [4:0] REG_FP   = 5'd30;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef enum logic {
    WB_PRI = 1'b0,
    LK_PRI = 1'b1
  } arb_state_t;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/regwr_starve_ctr.sv
// Counts consecutive cycles the link writer was refused; limit_hit flags the count the register takes next edge.
// limit_hit is combinational from inc/clr so the arbiter can flip priority on the same edge the count lands.
module regwr_starve_ctr
  import regfile_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic limit_hit
);

  logic [3:0] cnt;
  logic [3:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (clr) begin
      cnt_nxt = 4'd0;
    end else if (inc) begin
      cnt_nxt = sat_inc4(cnt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

  assign limit_hit = (cnt_nxt >= 4'(LIMIT));

endmodule

// File: rtl/regfile_write_arbiter.sv
// Two-requester (WB, link) arbiter for the single RF write port; grants are combinational, write port is one cycle later.
// Fixed WB priority with anti-starvation switch to link priority; optional read bypass under REGWR_BYPASS_EN.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              lk_valid,
  output logic              lk_ready,
  input  logic [DATA_W-1:0] lk_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              starved
`ifdef REGWR_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              byp_hit1,
  output logic              byp_hit2,
  output logic [DATA_W-1:0] byp_data1,
  output logic [DATA_W-1:0] byp_data2
`endif
);

  localparam logic [ADDR_W-1:0] RA_IDX   = ADDR_W'(REG_RA);
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  arb_state_t state;
  arb_state_t state_nxt;

  logic wb_gnt;
  logic lk_gnt;
  logic wb_is_ra;
  logic limit_hit;
  logic we_nxt;
  logic [ADDR_W-1:0] waddr_nxt;
  logic [DATA_W-1:0] wdata_nxt;

  assign wb_is_ra = (wb_addr == RA_IDX);

  // A pending WB to r31 comes from an older instruction, so it must land before the link write.
  always_comb begin
    wb_gnt = 1'b0;
    lk_gnt = 1'b0;
    case (state)
      WB_PRI: begin
        if (wb_valid) begin
          wb_gnt = 1'b1;
        end else if (lk_valid) begin
          lk_gnt = 1'b1;
        end
      end
      LK_PRI: begin
        if (wb_valid && wb_is_ra) begin
          wb_gnt = 1'b1;
        end else if (lk_valid) begin
          lk_gnt = 1'b1;
        end else if (wb_valid) begin
          wb_gnt = 1'b1;
        end
      end
      default: begin
        wb_gnt = 1'b0;
        lk_gnt = 1'b0;
      end
    endcase
  end

  regwr_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (lk_valid && !lk_gnt),
    .clr       (lk_gnt || !lk_valid),
    .limit_hit (limit_hit)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      WB_PRI:  if (limit_hit) state_nxt = LK_PRI;
      LK_PRI:  if (lk_gnt) state_nxt = WB_PRI;
      default: state_nxt = WB_PRI;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WB_PRI;
    end else begin
      state <= state_nxt;
    end
  end

  // Writes to r0 are accepted but never reach the register file.
  assign we_nxt    = lk_gnt || (wb_gnt && (wb_addr != ZERO_IDX));
  assign waddr_nxt = wb_gnt ? wb_addr : RA_IDX;
  assign wdata_nxt = wb_gnt ? wb_data : lk_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= we_nxt;
      if (we_nxt) begin
        rf_waddr <= waddr_nxt;
        rf_wdata <= wdata_nxt;
      end
    end
  end

  assign wb_ready = wb_gnt;
  assign lk_ready = lk_gnt;
  assign starved  = (state == LK_PRI);

`ifdef REGWR_BYPASS_EN
  assign byp_hit1  = rf_we && (rf_waddr == rd_addr1) && (rd_addr1 != ZERO_IDX);
  assign byp_hit2  = rf_we && (rf_waddr == rd_addr2) && (rd_addr2 != ZERO_IDX);
  assign byp_data1 = rf_wdata;
  assign byp_data2 = rf_wdata;
`endif

  a_one_grant : assert property (@(posedge clk) disable iff (!rst_n) !(wb_ready && lk_ready));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed scenarios plus a randomized run against a cycle-level reference model of the write arbiter.
module tb_regfile_write_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wb_valid;
  logic          wb_ready;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          lk_valid;
  logic          lk_ready;
  logic [DW-1:0] lk_data;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          starved;
`ifdef REGWR_BYPASS_EN
  logic [AW-1:0] rd_addr1;
  logic [AW-1:0] rd_addr2;
  logic          byp_hit1;
  logic          byp_hit2;
  logic [DW-1:0] byp_data1;
  logic [DW-1:0] byp_data2;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(
    .DATA_W       (DW),
    .ADDR_W       (AW),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .lk_valid  (lk_valid),
    .lk_ready  (lk_ready),
    .lk_data   (lk_data),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .starved   (starved)
`ifdef REGWR_BYPASS_EN
    ,
    .rd_addr1  (rd_addr1),
    .rd_addr2  (rd_addr2),
    .byp_hit1  (byp_hit1),
    .byp_hit2  (byp_hit2),
    .byp_data1 (byp_data1),
    .byp_data2 (byp_data2)
`endif
  );

  task automatic drive_idle();
    wb_valid = 1'b0;
    wb_addr  = '0;
    wb_data  = '0;
    lk_valid = 1'b0;
    lk_data  = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
`ifdef REGWR_BYPASS_EN
    rd_addr1 = '0;
    rd_addr2 = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", rf_we); end
    n_checks++; if (rf_waddr !== 5'd0) begin n_fail++; $display("FAIL reset_waddr: got %0d want 0", rf_waddr); end
    n_checks++; if (rf_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", rf_wdata); end
    n_checks++; if (starved !== 1'b0) begin n_fail++; $display("FAIL reset_starved: got %b want 0", starved); end
    @(negedge clk) rst_n = 1'b1;
    next_cycle();
    // build up starvation, then yank reset mid-cycle with both requests pending
    wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'hCAFE0009;
    lk_valid = 1'b1; lk_data = 32'h00400100;
    repeat (LIMIT) @(posedge clk);
    #1;
    n_checks++; if (starved !== 1'b1) begin n_fail++; $display("FAIL pre_reset_starved: got %b want 1", starved); end
    n_checks++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL pre_reset_we: got %b want 1", rf_we); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL midreset_we: got %b want 0", rf_we); end
    n_checks++; if (rf_waddr !== 5'd0) begin n_fail++; $display("FAIL midreset_waddr: got %0d want 0", rf_waddr); end
    n_checks++; if (rf_wdata !== 32'd0) begin n_fail++; $display("FAIL midreset_wdata: got %h want 0", rf_wdata); end
    n_checks++; if (starved !== 1'b0) begin n_fail++; $display("FAIL midreset_starved: got %b want 0", starved); end
    n_checks++; if (wb_ready !== 1'b1 || lk_ready !== 1'b0) begin
      n_fail++; $display("FAIL midreset_wbpri: got wb_ready=%b lk_ready=%b want 1/0", wb_ready, lk_ready);
    end
    drive_idle();
    @(negedge clk) rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_wb_only();
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
    #2;
    n_checks++; if (wb_ready !== 1'b1 || lk_ready !== 1'b0) begin
      n_fail++; $display("FAIL wb_only_ready: got wb=%b lk=%b want 1/0", wb_ready, lk_ready);
    end
    next_cycle();
    drive_idle();
    n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL wb_only_write: got we=%b a=%0d d=%h want 1/5/deadbeef", rf_we, rf_waddr, rf_wdata);
    end
    next_cycle();
    n_checks++; if (rf_we !== 1'b0 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL wb_only_hold: got we=%b a=%0d d=%h want 0/5/deadbeef", rf_we, rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_contention();
    lk_valid = 1'b1; lk_data = 32'h00400010;
    wb_valid = 1'b1; wb_addr = 5'd7;
    for (int i = 0; i < LIMIT; i++) begin
      wb_data = 32'hA0000000 + i;
      #2;
      n_checks++; if (wb_ready !== 1'b1 || lk_ready !== 1'b0 || starved !== 1'b0) begin
        n_fail++; $display("FAIL contend_wb_wins[%0d]: got wb=%b lk=%b st=%b want 1/0/0", i, wb_ready, lk_ready, starved);
      end
      next_cycle();
    end
    #2;
    n_checks++; if (starved !== 1'b1 || lk_ready !== 1'b1 || wb_ready !== 1'b0) begin
      n_fail++; $display("FAIL contend_lk_turn: got st=%b lk=%b wb=%b want 1/1/0", starved, lk_ready, wb_ready);
    end
    next_cycle();
    lk_valid = 1'b0;
    #1;
    n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd31 || rf_wdata !== 32'h00400010) begin
      n_fail++; $display("FAIL contend_lk_write: got we=%b a=%0d d=%h want 1/31/00400010", rf_we, rf_waddr, rf_wdata);
    end
    n_checks++; if (starved !== 1'b0 || wb_ready !== 1'b1) begin
      n_fail++; $display("FAIL contend_back_wbpri: got st=%b wb=%b want 0/1", starved, wb_ready);
    end
    next_cycle();
    drive_idle();
    next_cycle();
  endtask

  task automatic test_ordering();
    lk_valid = 1'b1; lk_data = 32'h00400030;
    wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h77;
    repeat (LIMIT) next_cycle();
    wb_addr = 5'd31; wb_data = 32'h11;
    #1;
    n_checks++; if (starved !== 1'b1 || wb_ready !== 1'b1 || lk_ready !== 1'b0) begin
      n_fail++; $display("FAIL order_wb_first: got st=%b wb=%b lk=%b want 1/1/0", starved, wb_ready, lk_ready);
    end
    next_cycle();
    wb_valid = 1'b0;
    #1;
    n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd31 || rf_wdata !== 32'h11) begin
      n_fail++; $display("FAIL order_wb_write: got we=%b a=%0d d=%h want 1/31/11", rf_we, rf_waddr, rf_wdata);
    end
    n_checks++; if (lk_ready !== 1'b1 || starved !== 1'b1) begin
      n_fail++; $display("FAIL order_lk_next: got lk=%b st=%b want 1/1", lk_ready, starved);
    end
    next_cycle();
    lk_valid = 1'b0;
    n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd31 || rf_wdata !== 32'h00400030 || starved !== 1'b0) begin
      n_fail++; $display("FAIL order_lk_final: got we=%b a=%0d d=%h st=%b want 1/31/00400030/0", rf_we, rf_waddr, rf_wdata, starved);
    end
    next_cycle();
  endtask

  task automatic test_r0_drop();
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
    #2;
    n_checks++; if (wb_ready !== 1'b1) begin n_fail++; $display("FAIL r0_ready: got %b want 1", wb_ready); end
    next_cycle();
    drive_idle();
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL r0_no_write: got %b want 0", rf_we); end
    next_cycle();
  endtask

`ifdef REGWR_BYPASS_EN
  task automatic test_bypass();
    rd_addr1 = 5'd8; rd_addr2 = 5'd0;
    wb_valid = 1'b1; wb_addr = 5'd8; wb_data = 32'h1234;
    next_cycle();
    drive_idle();
    n_checks++; if (byp_hit1 !== 1'b1 || byp_data1 !== 32'h1234 || byp_hit2 !== 1'b0) begin
      n_fail++; $display("FAIL bypass_hit1: got h1=%b d1=%h h2=%b want 1/1234/0", byp_hit1, byp_data1, byp_hit2);
    end
    rd_addr1 = 5'd9; rd_addr2 = 5'd8;
    #1;
    n_checks++; if (byp_hit1 !== 1'b0 || byp_hit2 !== 1'b1 || byp_data2 !== 32'h1234) begin
      n_fail++; $display("FAIL bypass_hit2: got h1=%b h2=%b d2=%h want 0/1/1234", byp_hit1, byp_hit2, byp_data2);
    end
    next_cycle();
    n_checks++; if (byp_hit2 !== 1'b0) begin n_fail++; $display("FAIL bypass_idle: got %b want 0", byp_hit2); end
  endtask
`endif

  // Model: who wins is decided by the arbitration rules; priority flips to the link writer
  // once it has been refused LIMIT cycles in a row and flips back after it is served.
  task automatic test_random();
    bit           m_lkpri;
    int           m_lost;
    bit           m_we;
    logic [4:0]   m_waddr;
    logic [31:0]  m_wdata;
    bit           e_wb;
    bit           e_lk;
    bit           wb_pend;
    bit           lk_pend;
    int           r;
    rst_n = 1'b0;
    drive_idle();
    @(negedge clk) rst_n = 1'b1;
    next_cycle();
    m_lkpri = 0; m_lost = 0; m_we = 0; m_waddr = '0; m_wdata = '0;
    wb_pend = 0; lk_pend = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!wb_pend) begin
        wb_valid = ($urandom_range(0, 9) < 6);
        r = $urandom_range(0, 9);
        wb_addr = (r == 0) ? 5'd0 : (r < 3) ? 5'd31 : 5'($urandom_range(0, 31));
        wb_data = $urandom;
      end
      if (!lk_pend) begin
        lk_valid = ($urandom_range(0, 9) < 5);
        lk_data = $urandom;
      end
      #2;
      e_wb = 0; e_lk = 0;
      if (wb_valid && lk_valid) begin
        if (m_lkpri && wb_addr != 5'd31) e_lk = 1; else e_wb = 1;
      end else if (wb_valid) begin
        e_wb = 1;
      end else if (lk_valid) begin
        e_lk = 1;
      end
      n_checks++; if (wb_ready !== e_wb) begin n_fail++; $display("FAIL rnd_wb_ready cyc %0d: got %b want %b", cyc, wb_ready, e_wb); end
      n_checks++; if (lk_ready !== e_lk) begin n_fail++; $display("FAIL rnd_lk_ready cyc %0d: got %b want %b", cyc, lk_ready, e_lk); end
      n_checks++; if (starved !== m_lkpri) begin n_fail++; $display("FAIL rnd_starved cyc %0d: got %b want %b", cyc, starved, m_lkpri); end
      n_checks++; if (rf_we !== m_we || rf_waddr !== m_waddr || rf_wdata !== m_wdata) begin
        n_fail++; $display("FAIL rnd_rf cyc %0d: got %b/%0d/%h want %b/%0d/%h", cyc, rf_we, rf_waddr, rf_wdata, m_we, m_waddr, m_wdata);
      end
      if (e_lk || !lk_valid) m_lost = 0;
      else if (m_lost < 15) m_lost++;
      if (m_lkpri) begin
        if (e_lk) m_lkpri = 0;
      end else if (m_lost >= LIMIT) begin
        m_lkpri = 1;
      end
      if (e_wb && wb_addr != 5'd0) begin
        m_we = 1; m_waddr = wb_addr; m_wdata = wb_data;
      end else if (e_lk) begin
        m_we = 1; m_waddr = 5'd31; m_wdata = lk_data;
      end else begin
        m_we = 0;
      end
      wb_pend = wb_valid && !e_wb;
      lk_pend = lk_valid && !e_lk;
      next_cycle();
    end
    drive_idle();
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_wb_only();
    test_contention();
    test_ordering();
    test_r0_drop();
`ifdef REGWR_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
